mem_access_unit: RTL and testbench

- Initiator-side load/store sequencer that drives the word-addressed data memory port: MemoryRead, MemoryWrite, word Address and WriteData out, ReadData in.
- Accepts one byte/half/word load or store at a time from the datapath over a valid/ready handshake.
- Sub-word stores become read-modify-write word sequences; sub-word loads are extracted and optionally sign-extended.
- Misaligned and out-of-range accesses return a fault without touching memory.

---
 rtl/mem_access_unit_if.sv | 31 +++
 rtl/mem_access_unit.sv | 212 +++++++++++++++++++++
 tb/tb_mem_access_unit.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/mem_access_unit_if.sv
// Request/response and memory-port bundle for mem_access_unit.
// The slave modport is the unit's view; master is the datapath/memory side.
interface mem_access_unit_if;
    logic        ReqValid;
    logic        ReqReady;
    logic        ReqWrite;
    logic [1:0]  ReqSize;
    logic        ReqSigned;
    logic [31:0] ReqAddr;
    logic [31:0] ReqWData;
    logic        RespValid;
    logic [31:0] RespData;
    logic        RespFault;
    logic [31:0] MemAddress;
    logic [31:0] MemWriteData;
    logic        MemoryRead;
    logic        MemoryWrite;
    logic [31:0] MemReadData;

    modport slave (
        input  ReqValid, ReqWrite, ReqSize, ReqSigned, ReqAddr, ReqWData, MemReadData,
        output ReqReady, RespValid, RespData, RespFault,
        output MemAddress, MemWriteData, MemoryRead, MemoryWrite
    );

    modport master (
        output ReqValid, ReqWrite, ReqSize, ReqSigned, ReqAddr, ReqWData, MemReadData,
        input  ReqReady, RespValid, RespData, RespFault,
        input  MemAddress, MemWriteData, MemoryRead, MemoryWrite
    );
endinterface

// File: rtl/mem_access_unit.sv
// Load/store sequencer for a word-addressed data memory: sub-word loads are
// lane-extracted, sub-word stores become read-modify-write, bad accesses fault.
module mem_access_unit #(
    parameter int DEPTH_WORDS = 64
) (
    input  logic              Clock,
    input  logic              Reset_L,
    mem_access_unit_if.slave  bus
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RD      = 3'd1,
        RD_WAIT = 3'd2,
        WR      = 3'd3,
        DONE    = 3'd4
    } state_t;

    localparam logic [31:0] DEPTH_W = 32'(DEPTH_WORDS);

    state_t      r_state;
    state_t      w_next;

    logic        r_write;
    logic [1:0]  r_size;
    logic        r_signed;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;

    logic        r_req_ready;
    logic        r_resp_valid;
    logic [31:0] r_resp_data;
    logic        r_resp_fault;
    logic [31:0] r_mem_addr;
    logic [31:0] r_mem_wdata;
    logic        r_mem_read;
    logic        r_mem_write;

    logic        w_accept;
    logic        w_fault;
    logic [31:0] w_addr_cur;
    logic [31:0] w_mem_addr;
    logic [31:0] w_mem_wdata;
    logic [31:0] w_resp_data;
    logic        w_resp_fault;

    function automatic logic access_fault(input logic [1:0] size, input logic [31:0] addr);
        logic f;
        case (size)
            2'b00:   f = 1'b0;
            2'b01:   f = addr[0];
            2'b10:   f = |addr[1:0];
            default: f = 1'b1;
        endcase
        if ({2'b00, addr[31:2]} >= DEPTH_W) begin
            f = 1'b1;
        end
        return f;
    endfunction

    // Little-endian lane select with optional sign extension.
    function automatic logic [31:0] lane_extract(input logic [31:0] word, input logic [1:0] size,
                                                 input logic [1:0] off, input logic sgn);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] res;
        b = word[{off, 3'b000} +: 8];
        h = off[1] ? word[31:16] : word[15:0];
        case (size)
            2'b00:   res = {{24{sgn & b[7]}}, b};
            2'b01:   res = {{16{sgn & h[15]}}, h};
            2'b10:   res = word;
            default: res = 32'h0000_0000;
        endcase
        return res;
    endfunction

    function automatic logic [31:0] lane_merge(input logic [31:0] word, input logic [31:0] data,
                                               input logic [1:0] size, input logic [1:0] off);
        logic [31:0] res;
        res = word;
        case (size)
            2'b00: res[{off, 3'b000} +: 8] = data[7:0];
            2'b01: begin
                if (off[1]) begin
                    res[31:16] = data[15:0];
                end else begin
                    res[15:0] = data[15:0];
                end
            end
            2'b10:   res = data;
            default: res = word;
        endcase
        return res;
    endfunction

    // Next-state decode and the values every registered output takes next cycle.
    always_comb begin
        w_next       = r_state;
        w_accept     = bus.ReqValid && r_req_ready;
        w_fault      = access_fault(bus.ReqSize, bus.ReqAddr);
        w_addr_cur   = (r_state == IDLE) ? bus.ReqAddr : r_addr;
        w_mem_addr   = 32'h0000_0000;
        w_mem_wdata  = 32'h0000_0000;
        w_resp_data  = 32'h0000_0000;
        w_resp_fault = 1'b0;

        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    if (w_fault) begin
                        w_next = DONE;
                    end else if (bus.ReqWrite && (bus.ReqSize == 2'b10)) begin
                        w_next = WR;
                    end else begin
                        w_next = RD;
                    end
                end else begin
                    w_next = IDLE;
                end
            end
            RD:      w_next = RD_WAIT;
            RD_WAIT: w_next = r_write ? WR : DONE;
            WR:      w_next = DONE;
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase

        if (w_next inside {RD, RD_WAIT, WR}) begin
            w_mem_addr = {w_addr_cur[31:2], 2'b00};
        end else begin
            w_mem_addr = 32'h0000_0000;
        end

        // A word store skips the read, so its data comes straight off the request.
        if (w_next == WR) begin
            if (r_state == IDLE) begin
                w_mem_wdata = bus.ReqWData;
            end else begin
                w_mem_wdata = lane_merge(bus.MemReadData, r_wdata, r_size, r_addr[1:0]);
            end
        end else begin
            w_mem_wdata = 32'h0000_0000;
        end

        if ((w_next == DONE) && (r_state == RD_WAIT) && !r_write) begin
            w_resp_data = lane_extract(bus.MemReadData, r_size, r_addr[1:0], r_signed);
        end else begin
            w_resp_data = 32'h0000_0000;
        end

        w_resp_fault = (r_state == IDLE) && (w_next == DONE);
    end

    // State register and registered outputs; reset drops the strobes immediately.
    always_ff @(posedge Clock or negedge Reset_L) begin
        if (!Reset_L) begin
            r_state      <= IDLE;
            r_req_ready  <= 1'b0;
            r_resp_valid <= 1'b0;
            r_resp_data  <= 32'h0000_0000;
            r_resp_fault <= 1'b0;
            r_mem_addr   <= 32'h0000_0000;
            r_mem_wdata  <= 32'h0000_0000;
            r_mem_read   <= 1'b0;
            r_mem_write  <= 1'b0;
        end else begin
            r_state      <= w_next;
            r_req_ready  <= (w_next == IDLE);
            r_resp_valid <= (w_next == DONE);
            r_resp_data  <= w_resp_data;
            r_resp_fault <= w_resp_fault;
            r_mem_addr   <= w_mem_addr;
            r_mem_wdata  <= w_mem_wdata;
            r_mem_read   <= (w_next == RD);
            r_mem_write  <= (w_next == WR);
        end
    end

    // Request fields captured at acceptance and held for the whole operation.
    always_ff @(posedge Clock or negedge Reset_L) begin
        if (!Reset_L) begin
            r_write  <= 1'b0;
            r_size   <= 2'b00;
            r_signed <= 1'b0;
            r_addr   <= 32'h0000_0000;
            r_wdata  <= 32'h0000_0000;
        end else if (w_accept) begin
            r_write  <= bus.ReqWrite;
            r_size   <= bus.ReqSize;
            r_signed <= bus.ReqSigned;
            r_addr   <= bus.ReqAddr;
            r_wdata  <= bus.ReqWData;
        end else begin
            r_write  <= r_write;
            r_size   <= r_size;
            r_signed <= r_signed;
            r_addr   <= r_addr;
            r_wdata  <= r_wdata;
        end
    end

    assign bus.ReqReady     = r_req_ready;
    assign bus.RespValid    = r_resp_valid;
    assign bus.RespData     = r_resp_data;
    assign bus.RespFault    = r_resp_fault;
    assign bus.MemAddress   = r_mem_addr;
    assign bus.MemWriteData = r_mem_wdata;
    assign bus.MemoryRead   = r_mem_read;
    assign bus.MemoryWrite  = r_mem_write;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit with a 64-word memory model
// (writes commit on negedge, reads sample on posedge).
module tb_mem_access_unit;

    logic clk;
    logic rst_n;
    mem_access_unit_if bus();

    mem_access_unit #(.DEPTH_WORDS(64)) dut (
        .Clock   (clk),
        .Reset_L (rst_n),
        .bus     (bus)
    );

    logic [31:0] mem [0:63];
    int n_cmp = 0;
    int n_err = 0;
    int rd_cnt = 0;
    int wr_cnt = 0;
    int both_cnt = 0;
    int acc_cnt = 0;
    logic [31:0] last_waddr = 32'h0;
    logic [31:0] last_wdata = 32'h0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory read port and strobe/acceptance monitor.
    always @(posedge clk) begin
        if (bus.MemoryRead) bus.MemReadData <= mem[bus.MemAddress[7:2]];
    end

    always @(negedge clk) begin
        if (bus.MemoryRead) rd_cnt++;
        if (bus.MemoryRead && bus.MemoryWrite) both_cnt++;
        if (bus.ReqValid && bus.ReqReady) acc_cnt++;
        if (bus.MemoryWrite) begin
            wr_cnt++;
            last_waddr = bus.MemAddress;
            last_wdata = bus.MemWriteData;
            mem[bus.MemAddress[7:2]] = bus.MemWriteData;
        end
    end

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic req_chk(input string tag, input logic wr, input logic [1:0] sz, input logic sgn,
                           input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [31:0] exp_data, input logic exp_fault, input int exp_lat,
                           input int exp_rd, input int exp_wr);
        int w;
        int lat;
        int rd0;
        int wr0;
        @(negedge clk);
        bus.ReqWrite  = wr;
        bus.ReqSize   = sz;
        bus.ReqSigned = sgn;
        bus.ReqAddr   = addr;
        bus.ReqWData  = wdata;
        bus.ReqValid  = 1'b1;
        w = 0;
        while (!bus.ReqReady && w < 20) begin
            @(negedge clk);
            w++;
        end
        if (!bus.ReqReady) begin
            check_val({tag, ".accept_timeout"}, 32'(bus.ReqReady), 32'h1);
            bus.ReqValid = 1'b0;
            return;
        end
        rd0 = rd_cnt;
        wr0 = wr_cnt;
        @(posedge clk);
        @(negedge clk);
        bus.ReqValid = 1'b0;
        bus.ReqAddr  = 32'hFFFF_FFFF;
        bus.ReqWData = 32'h0BAD_0BAD;
        lat = 1;
        while (!bus.RespValid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        check_val({tag, ".lat"},   32'(lat), 32'(exp_lat));
        check_val({tag, ".data"},  bus.RespData, exp_data);
        check_val({tag, ".fault"}, 32'(bus.RespFault), 32'(exp_fault));
        check_val({tag, ".nrd"},   32'(rd_cnt - rd0), 32'(exp_rd));
        check_val({tag, ".nwr"},   32'(wr_cnt - wr0), 32'(exp_wr));
    endtask

    logic [31:0] b2b_addr [0:2];
    logic [31:0] b2b_exp  [0:2];

    initial begin
        int n;
        int acc0;
        for (int i = 0; i < 64; i++) mem[i] = 32'h0;
        mem[8]  = 32'h1122_3344;
        mem[12] = 32'h8000_F0FF;
        mem[16] = 32'h0102_0304;
        rst_n = 1'b0;
        bus.ReqValid = 1'b0; bus.ReqWrite = 1'b0; bus.ReqSize = 2'b00;
        bus.ReqSigned = 1'b0; bus.ReqAddr = 32'h0; bus.ReqWData = 32'h0;

        #12;
        check_val("rst.ready",  32'(bus.ReqReady), 32'h0);
        check_val("rst.rvalid", 32'(bus.RespValid), 32'h0);
        check_val("rst.mrd",    32'(bus.MemoryRead), 32'h0);
        check_val("rst.mwr",    32'(bus.MemoryWrite), 32'h0);
        check_val("rst.maddr",  bus.MemAddress, 32'h0);
        check_val("rst.rdata",  bus.RespData, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_val("rst.ready_after", 32'(bus.ReqReady), 32'h1);

        req_chk("st_word", 1'b1, 2'b10, 1'b0, 32'h10, 32'hDEAD_BEEF, 32'h0, 1'b0, 2, 0, 1);
        check_val("st_word.waddr", last_waddr, 32'h10);
        check_val("st_word.wdata", last_wdata, 32'hDEAD_BEEF);
        check_val("st_word.mem",   mem[4], 32'hDEAD_BEEF);
        req_chk("ld_word", 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 32'hDEAD_BEEF, 1'b0, 3, 1, 0);

        req_chk("st_byte", 1'b1, 2'b00, 1'b1, 32'h22, 32'h1234_56AA, 32'h0, 1'b0, 4, 1, 1);
        check_val("st_byte.waddr", last_waddr, 32'h20);
        check_val("st_byte.wdata", last_wdata, 32'h11AA_3344);
        req_chk("ld_rmw", 1'b0, 2'b10, 1'b0, 32'h20, 32'h0, 32'h11AA_3344, 1'b0, 3, 1, 0);

        req_chk("ld_bs30", 1'b0, 2'b00, 1'b1, 32'h30, 32'h0, 32'hFFFF_FFFF, 1'b0, 3, 1, 0);
        req_chk("ld_hu30", 1'b0, 2'b01, 1'b0, 32'h30, 32'h0, 32'h0000_F0FF, 1'b0, 3, 1, 0);
        req_chk("ld_hs32", 1'b0, 2'b01, 1'b1, 32'h32, 32'h0, 32'hFFFF_8000, 1'b0, 3, 1, 0);
        req_chk("ld_bu33", 1'b0, 2'b00, 1'b0, 32'h33, 32'h0, 32'h0000_0080, 1'b0, 3, 1, 0);
        req_chk("ld_bs31", 1'b0, 2'b00, 1'b1, 32'h31, 32'h0, 32'hFFFF_FFF0, 1'b0, 3, 1, 0);

        req_chk("flt_word",  1'b0, 2'b10, 1'b0, 32'h12,  32'h0, 32'h0, 1'b1, 1, 0, 0);
        req_chk("flt_half",  1'b0, 2'b01, 1'b0, 32'h21,  32'h0, 32'h0, 1'b1, 1, 0, 0);
        req_chk("flt_size",  1'b0, 2'b11, 1'b0, 32'h10,  32'h0, 32'h0, 1'b1, 1, 0, 0);
        req_chk("flt_range", 1'b0, 2'b10, 1'b0, 32'h100, 32'h0, 32'h0, 1'b1, 1, 0, 0);
        req_chk("flt_st",    1'b1, 2'b10, 1'b0, 32'h100, 32'h5A5A_5A5A, 32'h0, 1'b1, 1, 0, 0);
        req_chk("ld_last",   1'b0, 2'b10, 1'b0, 32'hFC,  32'h0, 32'h0, 1'b0, 3, 1, 0);

        req_chk("st_half", 1'b1, 2'b01, 1'b0, 32'h32, 32'h7777_BEEF, 32'h0, 1'b0, 4, 1, 1);
        check_val("st_half.mem", mem[12], 32'hBEEF_F0FF);

        // Back-to-back loads with ReqValid held high.
        b2b_addr[0] = 32'h10; b2b_exp[0] = 32'hDEAD_BEEF;
        b2b_addr[1] = 32'h20; b2b_exp[1] = 32'h11AA_3344;
        b2b_addr[2] = 32'h30; b2b_exp[2] = 32'hBEEF_F0FF;
        @(negedge clk);
        bus.ReqWrite = 1'b0; bus.ReqSize = 2'b10; bus.ReqSigned = 1'b0;
        bus.ReqAddr = b2b_addr[0]; bus.ReqValid = 1'b1;
        acc0 = acc_cnt;
        for (int i = 0; i < 3; i++) begin
            check_val("b2b.ready_idle", 32'(bus.ReqReady), 32'h1);
            @(negedge clk);
            check_val("b2b.ready_busy", 32'(bus.ReqReady), 32'h0);
            if (i < 2) bus.ReqAddr = b2b_addr[i + 1];
            else bus.ReqValid = 1'b0;
            n = 1;
            while (!bus.RespValid && n < 20) begin
                @(negedge clk);
                n++;
                check_val("b2b.ready_busy", 32'(bus.ReqReady), 32'h0);
            end
            check_val("b2b.lat",  32'(n), 32'h3);
            check_val("b2b.data", bus.RespData, b2b_exp[i]);
            @(negedge clk);
        end
        check_val("b2b.accepts", 32'(acc_cnt - acc0), 32'h3);

        // Reset in the middle of a word store, before its commit edge.
        bus.ReqWrite = 1'b1; bus.ReqSize = 2'b10; bus.ReqAddr = 32'h40;
        bus.ReqWData = 32'h5555_5555; bus.ReqValid = 1'b1;
        check_val("rmid.ready", 32'(bus.ReqReady), 32'h1);
        @(posedge clk);
        #2;
        check_val("rmid.wr_on", 32'(bus.MemoryWrite), 32'h1);
        rst_n = 1'b0;
        bus.ReqValid = 1'b0;
        #1;
        check_val("rmid.wr_off", 32'(bus.MemoryWrite), 32'h0);
        check_val("rmid.addr0",  bus.MemAddress, 32'h0);
        @(negedge clk);
        @(negedge clk);
        check_val("rmid.ready_rst", 32'(bus.ReqReady), 32'h0);
        check_val("rmid.rvalid",    32'(bus.RespValid), 32'h0);
        rst_n = 1'b1;
        @(negedge clk);
        check_val("rmid.ready_back", 32'(bus.ReqReady), 32'h1);
        check_val("rmid.rvalid2",    32'(bus.RespValid), 32'h0);
        check_val("rmid.mem",        mem[16], 32'h0102_0304);
        check_val("both_strobes",    32'(both_cnt), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
